// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and chain index helpers for the scan-chain master and its bench model
package scan_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT, DONE} scan_state_e;
  function automatic int chain_len(input int nd, input int iw);
    return nd * iw;
  endfunction
  function automatic int addr_width(input int nd);
    return nd > 1 ? $clog2(nd) : 1;
  endfunction
  function automatic int slot_of(input int n, input int nd, input int iw);
    return nd - 1 - n / iw;
  endfunction
  function automatic int bit_of(input int n, input int iw);
    return iw - 1 - n % iw;
  endfunction
endpackage

// File: rtl/scan_clkgen.sv
// scan_clkgen: scan clock from a HALF_PERIOD phase counter, low while disabled, with rise/fall edge ticks
module scan_clkgen #(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sc_clk,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = en && cnt == CW'(HALF_PERIOD - 1);
  assign rise_tick = wrap && !sc_clk;
  assign fall_tick = wrap && sc_clk;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      sc_clk <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sc_clk <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) sc_clk <= !sc_clk;
    end
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: serialises a word into one design slot of the shared scan chain, latches, captures and reads back
module scan_chain_ctrl import scan_pkg::*; #(
  parameter int NUM_DESIGNS = 4,
  parameter int IO_WIDTH = 8,
  parameter int HALF_PERIOD = 1,
  localparam int ADDR_W = addr_width(NUM_DESIGNS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [IO_WIDTH-1:0] i_pins,
  output logic [IO_WIDTH-1:0] o_pins,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                sc_clk,
  output logic                sc_data,
  output logic                sc_select,
  output logic                sc_latch,
  input  logic                sc_return
);
  localparam int L = chain_len(NUM_DESIGNS, IO_WIDTH);
  localparam int CW = $clog2(L + 1);
  scan_state_e state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [L-1:0] sr_in, sr_out;
  logic en, gen_clk, rise_tick, fall_tick, last_bit, accept, bad_addr, go;
  assign accept = state == IDLE && start;
  assign bad_addr = int'(addr) >= NUM_DESIGNS;
  assign go = accept && !bad_addr;
  assign en = state inside {SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT};
  assign last_bit = bit_cnt == CW'(L - 1);
  scan_clkgen #(.HALF_PERIOD(HALF_PERIOD)) u_clkgen (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sc_clk(gen_clk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = go ? SHIFT_IN : IDLE;
      SHIFT_IN:  state_nx = fall_tick && last_bit ? LATCH : SHIFT_IN;
      LATCH:     state_nx = fall_tick ? CAPTURE : LATCH;
      CAPTURE:   state_nx = fall_tick ? SHIFT_OUT : CAPTURE;
      SHIFT_OUT: state_nx = fall_tick && last_bit ? DONE : SHIFT_OUT;
      default:   state_nx = IDLE;
    endcase
    busy = en;
    done = state == DONE;
    sc_clk = gen_clk && state != LATCH;
    sc_data = state == SHIFT_IN && sr_in[L-1];
    sc_select = state == CAPTURE;
    sc_latch = state == LATCH;
  end
  // chain position of slot s bit b is s*IO_WIDTH+b, so the word lands at its slot offset and shifts out MSB first
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      addr_q <= '0;
      sr_in <= '0;
      sr_out <= '0;
      o_pins <= '0;
      error <= 1'b0;
    end else begin
      state <= state_nx;
      error <= accept && bad_addr;
      if (go) begin
        addr_q <= addr;
        sr_in <= L'(i_pins) << (int'(addr) * IO_WIDTH);
      end
      if (fall_tick && (state == SHIFT_IN || state == SHIFT_OUT))
        bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
      if (fall_tick && state == SHIFT_IN) sr_in <= sr_in << 1;
      if (rise_tick && state == SHIFT_OUT) sr_out <= (sr_out << 1) | L'(sc_return);
      if (state == SHIFT_OUT && state_nx == DONE)
        o_pins <= IO_WIDTH'(sr_out >> (int'(addr_q) * IO_WIDTH));
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed checks of the scan-chain master against behavioural chain models
module tb_scan_chain_ctrl;
  import scan_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  int cyc = 0, cmp = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic start_a = 1'b0, busy_a, done_a, err_a, sck_a, sd_a, sel_a, lat_a, ret_a;
  logic [1:0] addr_a = '0;
  logic [7:0] pins_a = '0, o_a;
  logic [31:0] ch_a = '0, din_a = '0;
  scan_chain_ctrl u_a (
    .clk(clk), .reset(reset), .start(start_a), .addr(addr_a), .i_pins(pins_a), .o_pins(o_a),
    .busy(busy_a), .done(done_a), .error(err_a), .sc_clk(sck_a), .sc_data(sd_a),
    .sc_select(sel_a), .sc_latch(lat_a), .sc_return(ret_a)
  );
  // every design on chain A drives the inverse of its latched inputs
  always @(posedge sck_a) ch_a <= sel_a ? ~din_a : {ch_a[30:0], sd_a};
  always @(posedge clk) if (lat_a) din_a <= ch_a;
  assign ret_a = ch_a[31];

  logic start_b = 1'b0, busy_b, done_b, err_b, sck_b, sd_b, sel_b, lat_b, ret_b;
  logic [0:0] addr_b = '0;
  logic [3:0] pins_b = '0, o_b, ch_b = '0, din_b = '0;
  scan_chain_ctrl #(.NUM_DESIGNS(1), .IO_WIDTH(4), .HALF_PERIOD(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .addr(addr_b), .i_pins(pins_b), .o_pins(o_b),
    .busy(busy_b), .done(done_b), .error(err_b), .sc_clk(sck_b), .sc_data(sd_b),
    .sc_select(sel_b), .sc_latch(lat_b), .sc_return(ret_b)
  );
  always @(posedge sck_b) ch_b <= sel_b ? din_b : {ch_b[2:0], sd_b};
  always @(posedge clk) if (lat_b) din_b <= ch_b;
  assign ret_b = ch_b[3];

  task automatic txn_a(input logic [1:0] a, input logic [7:0] d, output int lat,
                       output logic [31:0] seq, output int both);
    int t0, n;
    logic prev;
    seq = '0; n = 0; both = 0; lat = -1; prev = 1'b0;
    addr_a = a; pins_a = d; start_a = 1'b1; t0 = cyc;
    @(negedge clk);
    start_a = 1'b0; addr_a = ~a; pins_a = ~d;
    for (int i = 0; i < 1000 && !done_a; i++) begin
      if (sck_a && !prev && n < 32) begin
        seq[n] = sd_a;
        n++;
      end
      if (sel_a && lat_a) both++;
      prev = sck_a;
      @(negedge clk);
    end
    if (done_a) lat = cyc - t0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp++; if ({busy_a, done_a, err_a, sck_a, sd_a, sel_a, lat_a, o_a} !== 15'd0) begin
      bad++; $display("FAIL reset_a: got %h want 0", {busy_a, done_a, err_a, sck_a, sd_a, sel_a, lat_a, o_a});
    end
    cmp++; if ({busy_b, done_b, err_b, sck_b, sd_b, sel_b, lat_b, o_b} !== 11'd0) begin
      bad++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, err_b, sck_b, sd_b, sel_b, lat_b, o_b});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cmp++; if ({busy_a, done_a, err_a, sck_a, o_a} !== 12'd0) begin
      bad++; $display("FAIL idle_after_reset: got %h want 0", {busy_a, done_a, err_a, sck_a, o_a});
    end
  endtask

  task automatic test_single();
    int lat, both;
    logic [31:0] seq;
    txn_a(2'd2, 8'hA5, lat, seq, both);
    cmp++; if (o_a !== 8'h5A) begin bad++; $display("FAIL single_o_pins: got %h want 5a", o_a); end
    cmp++; if (lat !== 133) begin bad++; $display("FAIL single_latency: got %0d want 133", lat); end
    cmp++; if (busy_a !== 1'b0) begin bad++; $display("FAIL single_busy_at_done: got %b want 0", busy_a); end
    cmp++; if (din_a !== 32'h00A5_0000) begin bad++; $display("FAIL single_chain: got %h want 00a50000", din_a); end
    cmp++; if (both !== 0) begin bad++; $display("FAIL latch_select_overlap: got %0d want 0", both); end
    @(negedge clk);
    cmp++; if (done_a !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done_a); end
  endtask

  task automatic test_slot_sweep();
    int lat, both;
    logic [31:0] seq, exp_seq;
    logic [7:0] d;
    for (int a = 0; a < 4; a++) begin
      d = 8'h01 << a;
      for (int n = 0; n < 32; n++) exp_seq[n] = slot_of(n, 4, 8) == a ? d[bit_of(n, 8)] : 1'b0;
      txn_a(2'(a), d, lat, seq, both);
      cmp++; if (seq !== exp_seq) begin bad++; $display("FAIL sweep_seq[%0d]: got %h want %h", a, seq, exp_seq); end
      cmp++; if (o_a !== ~d) begin bad++; $display("FAIL sweep_o_pins[%0d]: got %h want %h", a, o_a, ~d); end
      cmp++; if (din_a !== 32'(d) << (8 * a)) begin
        bad++; $display("FAIL sweep_chain[%0d]: got %h want %h", a, din_a, 32'(d) << (8 * a));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int t0, nd, d1, d2;
    logic b134, b135;
    nd = 0; d1 = -1; d2 = -1; b134 = 1'bx; b135 = 1'bx;
    addr_a = 2'd0; pins_a = 8'h80; start_a = 1'b1; t0 = cyc;
    for (int i = 0; i < 300; i++) begin
      if (done_a) begin
        nd++;
        if (nd == 1) d1 = cyc - t0; else if (nd == 2) d2 = cyc - t0;
      end
      if (cyc - t0 == 134) b134 = busy_a;
      if (cyc - t0 == 135) b135 = busy_a;
      @(negedge clk);
    end
    start_a = 1'b0;
    for (int i = 0; i < 400 && !done_a; i++) @(negedge clk);
    cmp++; if (nd !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    cmp++; if (d1 !== 133) begin bad++; $display("FAIL b2b_first_done: got %0d want 133", d1); end
    cmp++; if (d2 !== 267) begin bad++; $display("FAIL b2b_second_done: got %0d want 267", d2); end
    cmp++; if ({b134, b135} !== 2'b01) begin bad++; $display("FAIL b2b_reaccept: got %b want 01", {b134, b135}); end
    cmp++; if ({done_a, o_a} !== {1'b1, 8'h7F}) begin bad++; $display("FAIL b2b_drain: got %h want 17f", {done_a, o_a}); end
    @(negedge clk);
  endtask

  task automatic test_slow_clock();
    int t0, first, hi_run, hi_min, hi_max, hi_tot, lat;
    logic prev;
    first = -1; hi_run = 0; hi_min = 99; hi_max = 0; hi_tot = 0; prev = 1'b0;
    addr_b = 1'b0; pins_b = 4'h9; start_b = 1'b1; t0 = cyc;
    @(negedge clk);
    start_b = 1'b0; pins_b = 4'h6;
    for (int i = 0; i < 500 && !done_b; i++) begin
      if (sck_b) begin
        hi_run++; hi_tot++;
        if (!prev && first < 0) first = cyc - t0;
      end else if (prev) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      prev = sck_b;
      @(negedge clk);
    end
    lat = done_b ? cyc - t0 : -1;
    cmp++; if (o_b !== 4'h9) begin bad++; $display("FAIL slow_o_pins: got %h want 9", o_b); end
    cmp++; if (lat !== 61) begin bad++; $display("FAIL slow_latency: got %0d want 61", lat); end
    cmp++; if (first !== 4) begin bad++; $display("FAIL slow_first_rise: got %0d want 4", first); end
    cmp++; if ({hi_min, hi_max} !== {32'd3, 32'd3}) begin bad++; $display("FAIL slow_high_phase: got %0d..%0d want 3", hi_min, hi_max); end
    cmp++; if (hi_tot !== 27) begin bad++; $display("FAIL slow_high_cycles: got %0d want 27", hi_tot); end
    cmp++; if (din_b !== 4'h9) begin bad++; $display("FAIL slow_chain: got %h want 9", din_b); end
    @(negedge clk);
  endtask

  task automatic test_error();
    logic e1, b1, e2;
    int act;
    act = 0;
    addr_b = 1'b1; pins_b = 4'hF; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; e1 = err_b; b1 = busy_b;
    @(negedge clk);
    e2 = err_b;
    for (int i = 0; i < 20; i++) begin
      if (sck_b || busy_b || sel_b || lat_b) act++;
      @(negedge clk);
    end
    cmp++; if (e1 !== 1'b1) begin bad++; $display("FAIL error_pulse: got %b want 1", e1); end
    cmp++; if (b1 !== 1'b0) begin bad++; $display("FAIL error_busy: got %b want 0", b1); end
    cmp++; if (e2 !== 1'b0) begin bad++; $display("FAIL error_width: got %b want 0", e2); end
    cmp++; if (act !== 0) begin bad++; $display("FAIL error_scan_activity: got %0d want 0", act); end
    cmp++; if (o_b !== 4'h9) begin bad++; $display("FAIL error_o_pins_held: got %h want 9", o_b); end
  endtask

  task automatic test_reset_abort();
    int nd, lat, both;
    logic [31:0] seq;
    nd = 0;
    addr_a = 2'd2; pins_a = 8'hFF; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    cmp++; if ({busy_a, sd_a} !== 2'b11) begin bad++; $display("FAIL abort_pre_state: got %b want 11", {busy_a, sd_a}); end
    #1 reset = 1'b1;
    #1;
    cmp++; if ({busy_a, done_a, err_a, sck_a, sd_a, sel_a, lat_a} !== 7'd0) begin
      bad++; $display("FAIL abort_outputs: got %b want 0", {busy_a, done_a, err_a, sck_a, sd_a, sel_a, lat_a});
    end
    cmp++; if (o_a !== 8'h00) begin bad++; $display("FAIL abort_o_pins: got %h want 00", o_a); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (done_a || busy_a) nd++;
      @(negedge clk);
    end
    cmp++; if (nd !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", nd); end
    txn_a(2'd1, 8'h3C, lat, seq, both);
    cmp++; if (o_a !== 8'hC3) begin bad++; $display("FAIL abort_recover_o_pins: got %h want c3", o_a); end
    cmp++; if (lat !== 133) begin bad++; $display("FAIL abort_recover_latency: got %0d want 133", lat); end
    cmp++; if (din_a !== 32'h0000_3C00) begin bad++; $display("FAIL abort_recover_chain: got %h want 00003c00", din_a); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_slot_sweep();
    test_back_to_back();
    test_slow_clock();
    test_error();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
